// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 message padder:
//   state_t   - padder FSM states (ACCEPT, PAD, EMIT)
//   BLOCK_W   - width of one padded message block (512)
//   WORD_W    - width of one input/buffer word (32)
//   NUM_WORDS - words per block (16)
//   PAD_WORD  - a word holding only the 0x80 end-of-message marker
// -----------------------------------------------------------------------------
package sha256_pkg;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    PAD    = 2'd1,
    EMIT   = 2'd2
  } state_t;

  localparam int BLOCK_W   = 512;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = BLOCK_W / WORD_W;

  localparam logic [WORD_W-1:0] PAD_WORD = 32'h8000_0000;

endpackage

// File: rtl/sha256_pad_word.sv
// -----------------------------------------------------------------------------
// sha256_pad_word
// Combinational masking of one big-endian message word.
// Bytes at positions >= in_bytes are cleared, and the byte at position
// in_bytes (when it is 0..3) receives the 0x80 end-of-message marker.
// A full word (in_bytes >= 4) passes through unchanged.
// Ports:
//   in_data  [31:0] message word, first byte in [31:24]
//   in_bytes [2:0]  number of valid bytes in in_data
//   out_word [31:0] masked word with marker inserted
// -----------------------------------------------------------------------------
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] in_data,
  input  logic [2:0]        in_bytes,
  output logic [WORD_W-1:0] out_word
);

  always_comb begin
    out_word = '0;
    for (int k = 0; k < 4; k++) begin
      // Byte k sits at bits [31-8k -: 8] (byte 0 is the most significant).
      if (3'(k) < in_bytes) begin
        out_word[31-8*k -: 8] = in_data[31-8*k -: 8];
      end else if (3'(k) == in_bytes) begin
        out_word[31-8*k -: 8] = 8'h80;
      end
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// -----------------------------------------------------------------------------
// sha256_padder
// Applies SHA-256 message padding (0x80 marker, zero fill, 64-bit bit length)
// to a byte-granular stream of 32-bit big-endian words and emits complete
// 512-bit blocks, word 0 on out_block[0:31].
//
// Parameters:
//   LEN_W     width of the bit-length counter (3..64), zero-extended to 64
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous active-low reset
//   in_data   [31:0] message word, first byte in [31:24]
//   in_valid  input word valid
//   in_ready  padder can accept a word (only in the accept phase)
//   in_last   final word of the message
//   in_bytes  [2:0] valid bytes of a last word (0..4; 4 when not last)
//   out_block [0:511] padded block
//   out_valid out_block valid
//   out_ready downstream core accepts the block
//   out_first block is the first of its message
//   out_last  block is the final padded block of its message
// Optional (SHA256_PADDER_STATS_EN defined):
//   blk_count [31:0] output blocks handshaked, wraps
//   msg_count [15:0] final blocks handshaked, wraps
// -----------------------------------------------------------------------------
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [2:0]          in_bytes,
  output logic [0:BLOCK_W-1]  out_block,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_first,
  output logic                out_last
`ifdef SHA256_PADDER_STATS_EN
  ,
  output logic [31:0]         blk_count,
  output logic [15:0]         msg_count
`endif
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_widx;
  logic [WORD_W-1:0] r_buf [NUM_WORDS];
  logic [LEN_W-1:0]  r_bitlen;
  logic              r_pad_pending;   // 0x80 marker still owed to the block
  logic              r_first_flag;
  logic              r_final;         // block in EMIT carries the length field
  logic              r_padding_phase; // after EMIT, continue padding

  logic [WORD_W-1:0] w_in_word;
  logic [63:0]       w_len64;
  logic              w_in_fire;
  logic              w_out_fire;

  sha256_pad_word u_pad_word (
    .in_data  (in_data),
    .in_bytes (in_bytes),
    .out_word (w_in_word)
  );

  assign w_in_fire  = (r_state == ACCEPT) && in_valid;
  assign w_out_fire = (r_state == EMIT) && out_ready;
  assign w_len64    = 64'(r_bitlen);

  // Buffer word i maps to out_block[32*i +: 32]; on the ascending vector the
  // word's MSB lands on the lowest index, so byte 0 ends up on bits [0:7].
  always_comb begin
    out_block = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      out_block[i*WORD_W +: WORD_W] = r_buf[i];
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ACCEPT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_first   = 1'b0;
    out_last    = 1'b0;
    unique case (r_state)
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (r_widx == 4'd15) begin
            w_state_nxt = EMIT;
          end else if (in_last) begin
            w_state_nxt = PAD;
          end
        end
      end
      PAD: begin
        if (r_pad_pending) begin
          if (r_widx == 4'd15) begin
            w_state_nxt = EMIT;
          end
        end else if (r_widx > 4'd13) begin
          // Word 14 takes the length (final block); word 15 means the length
          // no longer fits and another block follows.
          w_state_nxt = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_first = r_first_flag;
        out_last  = r_final;
        if (out_ready) begin
          if (r_final) begin
            w_state_nxt = ACCEPT;
          end else if (r_padding_phase) begin
            w_state_nxt = PAD;
          end else begin
            w_state_nxt = ACCEPT;
          end
        end
      end
      default: w_state_nxt = ACCEPT;
    endcase
  end

  // Block buffer, word index, bit length and message flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        r_buf[i] <= '0;
      end
      r_widx          <= '0;
      r_bitlen        <= '0;
      r_pad_pending   <= 1'b0;
      r_first_flag    <= 1'b1;
      r_final         <= 1'b0;
      r_padding_phase <= 1'b0;
    end else begin
      unique case (r_state)
        ACCEPT: begin
          if (w_in_fire) begin
            r_buf[r_widx] <= w_in_word;
            r_bitlen      <= r_bitlen + LEN_W'({in_bytes, 3'b000});
            r_pad_pending <= in_last && (in_bytes == 3'd4);
            if (r_widx == 4'd15) begin
              r_final         <= 1'b0;
              r_padding_phase <= in_last;
            end else begin
              r_widx <= r_widx + 4'd1;
            end
          end
        end
        PAD: begin
          if (r_pad_pending) begin
            r_buf[r_widx] <= PAD_WORD;
            r_pad_pending <= 1'b0;
            if (r_widx == 4'd15) begin
              r_final         <= 1'b0;
              r_padding_phase <= 1'b1;
            end else begin
              r_widx <= r_widx + 4'd1;
            end
          end else if (r_widx <= 4'd13) begin
            r_buf[r_widx] <= '0;
            r_widx        <= r_widx + 4'd1;
          end else if (r_widx == 4'd14) begin
            r_buf[14] <= w_len64[63:32];
            r_buf[15] <= w_len64[31:0];
            r_final   <= 1'b1;
          end else begin
            r_buf[15]       <= '0;
            r_final         <= 1'b0;
            r_padding_phase <= 1'b1;
          end
        end
        EMIT: begin
          if (w_out_fire) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
              r_buf[i] <= '0;
            end
            r_widx <= '0;
            // The next block is a message's first block only after a final one.
            r_first_flag <= r_final;
            if (r_final) begin
              r_bitlen <= '0;
              r_final  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHA256_PADDER_STATS_EN
  logic [31:0] r_blk_count;
  logic [15:0] r_msg_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blk_count <= '0;
      r_msg_count <= '0;
    end else if (w_out_fire) begin
      r_blk_count <= r_blk_count + 32'd1;
      if (r_final) begin
        r_msg_count <= r_msg_count + 16'd1;
      end
    end
  end

  assign blk_count = r_blk_count;
  assign msg_count = r_msg_count;
`endif

endmodule

// File: tb/tb_sha256_padder.sv
// -----------------------------------------------------------------------------
// tb_sha256_padder
// Directed bench for sha256_padder: reset state, "abc", empty message,
// a 5-byte message, 56- and 64-byte messages, output backpressure and a
// reset in the middle of a message.
// -----------------------------------------------------------------------------
module tb_sha256_padder;

  logic         clk;
  logic         reset;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [2:0]   in_bytes;
  // Packed [511:0]: DUT bit [0] (word 0 MSB) appears as bit [511] here.
  logic [511:0] out_block;
  logic         out_valid;
  logic         out_ready;
  logic         out_first;
  logic         out_last;

  int n_checks = 0;
  int n_errors = 0;

  sha256_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .out_block (out_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_first (out_first),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] put(input logic [511:0] b, input int idx, input logic [31:0] w);
    logic [511:0] r;
    r = b;
    r[511-32*idx -: 32] = w;
    return r;
  endfunction

  // Present one word and hold it until the padder takes it.
  task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] b);
    int n;
    n = 0;
    in_data  = d;
    in_last  = l;
    in_bytes = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", {511'd0, in_ready}, 512'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait (bounded) for a block, sample it, then handshake it.
  task automatic get_block(input string tag, output logic [511:0] blk,
                           output logic f, output logic l, output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
    chk({tag, "_valid"}, {511'd0, out_valid}, 512'd1);
    blk = out_block;
    f   = out_first;
    l   = out_last;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [511:0] blk, exp, held;
  logic         f, l, hf, hl;
  int           lat;

  initial begin
    reset     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_bytes  = 3'd4;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_in_ready",  {511'd0, in_ready},  512'd1);
    chk("rst_out_valid", {511'd0, out_valid}, 512'd0);
    chk("rst_out_block", out_block, 512'd0);
    chk("rst_out_first", {511'd0, out_first}, 512'd0);
    chk("rst_out_last",  {511'd0, out_last},  512'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // "abc": trailing byte carries junk that must be masked off
    send_word(32'h616263FF, 1'b1, 3'd3);
    get_block("abc", blk, f, l, lat);
    chk("abc_block", blk, {32'h61626380, 416'd0, 64'h18});
    chk("abc_first", {511'd0, f}, 512'd1);
    chk("abc_last",  {511'd0, l}, 512'd1);
    chk("abc_latency_le17", {511'd0, (lat >= 1 && lat <= 17)}, 512'd1);

    // Empty message
    send_word(32'hDEADBEEF, 1'b1, 3'd0);
    get_block("empty", blk, f, l, lat);
    chk("empty_block", blk, {32'h80000000, 480'd0});
    chk("empty_first", {511'd0, f}, 512'd1);
    chk("empty_last",  {511'd0, l}, 512'd1);

    // 5-byte message: second word holds one byte
    send_word(32'hAABBCCDD, 1'b0, 3'd4);
    send_word(32'hEE123456, 1'b1, 3'd1);
    get_block("five", blk, f, l, lat);
    chk("five_block", blk, {32'hAABBCCDD, 32'hEE800000, 384'd0, 64'h28});
    chk("five_flags", {510'd0, f, l}, 512'd3);

    // 56-byte message: marker fills word 14, length needs a second block
    for (int i = 0; i < 14; i++) send_word(32'h10203040 + i, (i == 13), 3'd4);
    exp = '0;
    for (int i = 0; i < 14; i++) exp = put(exp, i, 32'h10203040 + i);
    exp = put(exp, 14, 32'h80000000);
    get_block("m56_b1", blk, f, l, lat);
    chk("m56_b1_block", blk, exp);
    chk("m56_b1_flags", {510'd0, f, l}, 512'd2);
    get_block("m56_b2", blk, f, l, lat);
    chk("m56_b2_block", blk, {448'd0, 64'h1C0});
    chk("m56_b2_flags", {510'd0, f, l}, 512'd1);

    // 64-byte message: marker opens the second block
    for (int i = 0; i < 16; i++) send_word(32'hA0000000 + (i << 8) + i, (i == 15), 3'd4);
    exp = '0;
    for (int i = 0; i < 16; i++) exp = put(exp, i, 32'hA0000000 + (i << 8) + i);
    get_block("m64_b1", blk, f, l, lat);
    chk("m64_b1_block", blk, exp);
    chk("m64_b1_flags", {510'd0, f, l}, 512'd2);
    get_block("m64_b2", blk, f, l, lat);
    chk("m64_b2_block", blk, {32'h80000000, 416'd0, 64'h200});
    chk("m64_b2_flags", {510'd0, f, l}, 512'd1);

    // Backpressure: block and flags held while out_ready stays low
    send_word(32'h61626300, 1'b1, 3'd3);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 60) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("bp_valid", {511'd0, out_valid}, 512'd1);
    held = out_block;
    hf   = out_first;
    hl   = out_last;
    chk("bp_block", held, {32'h61626380, 416'd0, 64'h18});
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_block", out_block, held);
      chk("bp_hold_flags", {509'd0, out_valid, out_first, out_last}, {509'd0, 1'b1, hf, hl});
      chk("bp_in_ready", {511'd0, in_ready}, 512'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_single_handshake", {510'd0, out_valid, in_ready}, 512'd1);
    @(posedge clk); #1;
    chk("bp_no_repeat", {511'd0, out_valid}, 512'd0);

    // Reset after 5 words of a message, then "abc"
    for (int i = 0; i < 5; i++) send_word(32'h55550000 + i, 1'b0, 3'd4);
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", {511'd0, out_valid}, 512'd0);
    chk("mid_rst_in_ready",  {511'd0, in_ready},  512'd1);
    chk("mid_rst_block",     out_block, 512'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    send_word(32'h61626300, 1'b1, 3'd3);
    get_block("post_rst", blk, f, l, lat);
    chk("post_rst_block", blk, {32'h61626380, 416'd0, 64'h18});
    chk("post_rst_flags", {510'd0, f, l}, 512'd3);
    @(posedge clk); #1;
    chk("post_rst_idle", {511'd0, out_valid}, 512'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
